// File: rtl/operand_bit_serializer_pkg.sv
// rtl/operand_bit_serializer_pkg.sv - shared RSA datapath types for the operand serializer
package operand_bit_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } obs_state_e;

  // Registered output bundle, kept together so every state transition sets all outputs at once
  typedef struct packed {
    logic ready;
    logic load_o;
    logic en_o;
    logic a_i;
    logic done;
  } obs_out_t;

  localparam obs_out_t OUT_IDLE = '{ready: 1'b1, load_o: 1'b0, en_o: 1'b0, a_i: 1'b0, done: 1'b0};
  localparam obs_out_t OUT_LOAD = '{ready: 1'b0, load_o: 1'b1, en_o: 1'b0, a_i: 1'b0, done: 1'b0};
  localparam obs_out_t OUT_DONE = '{ready: 1'b0, load_o: 1'b0, en_o: 1'b0, a_i: 1'b0, done: 1'b1};

endpackage

// File: rtl/operand_bit_serializer.sv
// rtl/operand_bit_serializer.sv - serializes an operand one bit per cycle for a bit-serial adder
module operand_bit_serializer
  import operand_bit_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic                  ready,
  output logic                  load_o,
  output logic                  en_o,
  output logic                  a_i,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  obs_state_e            state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      cnt;
  obs_out_t              outs;

  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? v[DATA_WIDTH-1] : v[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? {v[DATA_WIDTH-2:0], 1'b0} : {1'b0, v[DATA_WIDTH-1:1]};
  endfunction

  // a_i is registered, so each edge loads the bit at the head of the register and shifts it out
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      outs  <= OUT_IDLE;
    end else if (ce) begin
      if (abort) begin
        state <= IDLE;
        shreg <= '0;
        cnt   <= '0;
        outs  <= OUT_IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= LOAD;
              shreg <= operand;
              outs  <= OUT_LOAD;
            end
          end
          LOAD: begin
            state <= SHIFT;
            cnt   <= CNT_LAST;
            shreg <= advance(shreg);
            outs  <= '{ready: 1'b0, load_o: 1'b0, en_o: 1'b1, a_i: head_bit(shreg), done: 1'b0};
          end
          SHIFT: begin
            if (cnt == '0) begin
              state <= DONE;
              outs  <= OUT_DONE;
            end else begin
              cnt      <= cnt - 1'b1;
              shreg    <= advance(shreg);
              outs.a_i <= head_bit(shreg);
            end
          end
          DONE: begin
            state <= IDLE;
            outs  <= OUT_IDLE;
          end
          default: begin
            state <= IDLE;
            outs  <= OUT_IDLE;
          end
        endcase
      end
    end
  end

  assign ready  = outs.ready;
  assign load_o = outs.load_o;
  assign en_o   = outs.en_o;
  assign a_i    = outs.a_i;
  assign done   = outs.done;

endmodule

// File: tb/tb_operand_bit_serializer.sv
// tb/tb_operand_bit_serializer.sv - directed self-checking bench for operand_bit_serializer
module tb_operand_bit_serializer;

  logic       clk = 1'b0;
  logic       rst, ce, start, abort;
  logic [7:0] operand;
  logic       ready_m, load_m, en_m, a_m, done_m;
  logic       ready_l, load_l, en_l, a_l, done_l;
  int         checks = 0;
  int         errors = 0;
  int         en_edges = 0;
  logic [7:0] exp_bits;

  always #5 clk = ~clk;

  operand_bit_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .abort(abort), .operand(operand),
    .ready(ready_m), .load_o(load_m), .en_o(en_m), .a_i(a_m), .done(done_m)
  );

  operand_bit_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .abort(abort), .operand(operand),
    .ready(ready_l), .load_o(load_l), .en_o(en_l), .a_i(a_l), .done(done_l)
  );

  // ce-qualified edges on which the MSB-first instance presents a bit
  always @(posedge clk) if (en_m && ce) en_edges++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs_m();
    return {3'b000, ready_m, load_m, en_m, a_m, done_m};
  endfunction

  function automatic logic [7:0] outs_l();
    return {3'b000, ready_l, load_l, en_l, a_l, done_l};
  endfunction

  function automatic logic [7:0] bit_out(input logic b);
    return {5'b00001, b, 1'b0} >> 0 & 8'h06 | {6'b0, b, 1'b0};
  endfunction

  initial begin
    rst = 1'b0; ce = 1'b1; start = 1'b0; abort = 1'b0; operand = 8'h00;
    tick(); tick();
    chk("reset_msb", outs_m(), 8'b10000);
    chk("reset_lsb", outs_l(), 8'b10000);
    rst = 1'b1;
    tick();
    chk("idle_msb", outs_m(), 8'b10000);

    // basic stream, both bit orders; operand changed right after capture
    operand = 8'b01011011; start = 1'b1;
    tick();
    start = 1'b0; operand = 8'h00;
    chk("t1_load_msb", outs_m(), 8'b01000);
    chk("t1_load_lsb", outs_l(), 8'b01000);
    exp_bits = 8'b01011011;
    for (int n = 0; n < 8; n++) begin
      tick();
      chk($sformatf("t1_msb_bit%0d", n), outs_m(), {6'b0, 1'b1, exp_bits[7-n]} << 1);
      chk($sformatf("t1_lsb_bit%0d", n), outs_l(), {6'b0, 1'b1, exp_bits[n]} << 1);
    end
    tick();
    chk("t1_done_msb", outs_m(), 8'b00001);
    chk("t1_done_lsb", outs_l(), 8'b00001);
    tick();
    chk("t1_ready_msb", outs_m(), 8'b10000);

    // ce held low for 3 cycles after the 4th bit
    operand = 8'b00101010; start = 1'b1;
    tick();
    start = 1'b0;
    en_edges = 0;
    chk("t3_load", outs_m(), 8'b01000);
    exp_bits = 8'b00101010;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("t3_bit%0d", n), outs_m(), {6'b0, 1'b1, exp_bits[7-n]} << 1);
    end
    ce = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk($sformatf("t3_hold%0d", n), outs_m(), 8'b00100);
    end
    ce = 1'b1;
    for (int n = 4; n < 8; n++) begin
      tick();
      chk($sformatf("t3_bit%0d", n), outs_m(), {6'b0, 1'b1, exp_bits[7-n]} << 1);
    end
    tick();
    chk("t3_done", outs_m(), 8'b00001);
    chk("t3_en_edges", 8'(en_edges), 8'd8);
    tick();
    chk("t3_ready", outs_m(), 8'b10000);

    // start with a new operand during SHIFT is ignored
    operand = 8'hCA; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_load", outs_m(), 8'b01000);
    exp_bits = 8'hCA;
    for (int n = 0; n < 8; n++) begin
      if (n == 2) begin start = 1'b1; operand = 8'hFF; end
      if (n == 5) start = 1'b0;
      tick();
      chk($sformatf("t4_bit%0d", n), outs_m(), {6'b0, 1'b1, exp_bits[7-n]} << 1);
    end
    tick();
    chk("t4_done", outs_m(), 8'b00001);
    tick();
    chk("t4_ready", outs_m(), 8'b10000);

    // abort after the 3rd bit, abort beats start in IDLE, then a fresh operand
    operand = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_load", outs_m(), 8'b01000);
    exp_bits = 8'hA5;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk($sformatf("t5_bit%0d", n), outs_m(), {6'b0, 1'b1, exp_bits[7-n]} << 1);
    end
    abort = 1'b1;
    tick();
    chk("t5_abort_idle", outs_m(), 8'b10000);
    start = 1'b1;
    tick();
    chk("t5_abort_beats_start", outs_m(), 8'b10000);
    abort = 1'b0; start = 1'b0;
    tick();
    chk("t5_no_done", outs_m(), 8'b10000);
    operand = 8'h81; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5b_load", outs_m(), 8'b01000);
    exp_bits = 8'h81;
    for (int n = 0; n < 8; n++) begin
      tick();
      chk($sformatf("t5b_bit%0d", n), outs_m(), {6'b0, 1'b1, exp_bits[7-n]} << 1);
    end
    tick();
    chk("t5b_done", outs_m(), 8'b00001);
    tick();
    chk("t5b_ready", outs_m(), 8'b10000);

    // reset mid-SHIFT overrides ce and leaves no done pulse
    operand = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("t6_shift_bit1", outs_m(), 8'b00100);
    rst = 1'b0; ce = 1'b0;
    tick();
    chk("t6_reset", outs_m(), 8'b10000);
    rst = 1'b1; ce = 1'b1;
    tick();
    chk("t6_no_done0", outs_m(), 8'b10000);
    tick();
    chk("t6_no_done1", outs_m(), 8'b10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
